alu_serial_ctrl: RTL
====================

// Module: alu_serial_ctrl
// PURPOSE
//   Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice
//   and also consumes what the slice produces.
//   - Accepts WIDTH-bit operands and an opcode through a start/done handshake.
//   - Feeds the slice one bit pair per cycle, LSB first, recirculating carry.
//   - Assembles the slice outputs into a WIDTH-bit result plus flags.
//   - The slice is instantiated by the parent and wired to the s_* ports.
// PARAMETERS
//   WIDTH  4  operand/result width; number of SHIFT cycles per operation (>=2)
// PORTS
//   clk     in   1      clock; all state updates on rising edge
//   rst     in   1      reset, asynchronous, active-high
//   start   in   1      request; accepted only in IDLE
//   op      in   2      00 ADD A+B; 01 SUB B-A; 10 CMP; 11 AND
//   a       in   WIDTH  operand A, sampled when start is accepted
//   b       in   WIDTH  operand B, sampled when start is accepted
//   busy    out  1      high in SHIFT and DONE
//   done    out  1      one-cycle pulse; result and flags valid from here on
//   result  out  WIDTH  ADD/SUB/AND result; all zeros for CMP
//   carry   out  1      ADD: carry out; SUB: 1 = no borrow; else 0
//   neg     out  1      ADD/SUB: result[WIDTH-1]; else 0
//   eq      out  1      CMP: A==B; else 0
//   gt      out  1      CMP: A>B (unsigned); else 0
//   lt      out  1      CMP: A<B (unsigned); else 0
//   s_a     out  1      slice A input = current bit of A shift reg
//   s_b     out  1      slice B input = current bit of B shift reg
//   s_cin   out  1      slice Cin input
//   s_m0    out  1      slice M0 = op_q[0]
//   s_m1    out  1      slice M1 = op_q[1]
//   s_f     in   1      slice F (sum / A==B bit / AND bit)
//   s_cout  in   1      slice Cout (carry / A>B bit)
//   s_n     in   1      slice N (A<B bit in CMP)
// BEHAVIOUR
//   Reset: FSM=IDLE.
//     - All outputs and internal registers 0: busy, done, result, carry,
//       neg, eq, gt, lt, s_*.
//     - Asserting rst mid-operation aborts the operation; no done pulse.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE:
//     - start=1: latch a, b, op into shift regs / op_q; bit counter = 0.
//     - cy_q = 1 if op==SUB, else 0.
//     - Clear result and all flags; go to SHIFT.
//     - start=0: stay in IDLE.
//   SHIFT: one bit per cycle, WIDTH cycles total (counter 0..WIDTH-1).
//     - Slice drive is combinational from registers:
//       s_a = a_sh[0]; s_b = b_sh[0]; s_cin = cy_q; s_m1/s_m0 = op_q.
//     - Each edge: shift a_sh and b_sh right.
//     - ADD/SUB/AND: shift s_f into result MSB (result shifts right).
//     - ADD/SUB: cy_q <= s_cout. CMP/AND: cy_q unchanged.
//     - CMP, LSB-first, a higher differing bit overrides a lower one:
//       running eq_q <= eq_q & s_f on every bit, with eq_q = 1 at bit 0;
//       if s_f=0 then gt <= s_cout and lt <= s_n; if s_f=1, gt/lt hold.
//     - On the counter = WIDTH-1 edge:
//       carry <= s_cout (ADD/SUB only); neg <= final result MSB (ADD/SUB only);
//       eq <= final eq_q (CMP only); go to DONE.
//   DONE: done=1 for exactly one cycle, then IDLE.
//   Latency: start accepted at edge 0; done high during cycle WIDTH+1.
//     - Back-to-back start is accepted in the cycle after done.
//   Outputs hold their last values in IDLE until the next start is accepted.
//   start while busy is ignored; it is not queued.
//   In IDLE and DONE, s_a=s_b=s_cin=0 and s_m1/s_m0 = op_q.
//   Arithmetic is modulo 2^WIDTH; no overflow flag.
//   SUB relies on the slice inverting A in mode 01: computes B + ~A + 1.
// TESTING
//   1. ADD a=7, b=9 (WIDTH=4) -> done at cycle 5; result=0000, carry=1, neg=0.
//   2. SUB a=3, b=5 -> result=0010, carry=1, neg=0.
//      SUB a=5, b=3 -> result=1110, carry=0, neg=1.
//   3. CMP a=6, b=6 -> eq=1, gt=0, lt=0.
//      CMP a=9, b=6 -> gt=1.
//      CMP a=1, b=8 -> lt=1 (MSB overrides the lower differing bit).
//   4. AND a=1100, b=1010 -> result=1000, carry=neg=eq=gt=lt=0.
//   5. start pulsed again in SHIFT with different operands
//      -> ignored; first result is unchanged; exactly one done pulse.
//   6. rst asserted during SHIFT cycle 2 -> immediate IDLE, all outputs 0,
//      no done; a new op after release completes correctly.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU slice: shifts operand bits out LSB first,
// recirculates carry, and gathers slice outputs into a WIDTH-bit result and flags.
module alu_serial_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             neg,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             s_a,
  output logic             s_b,
  output logic             s_cin,
  output logic             s_m0,
  output logic             s_m1,
  input  logic             s_f,
  input  logic             s_cout,
  input  logic             s_n
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             cy_q, eq_q;
  logic             arith, is_cmp;

  assign arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_cmp = (op_q == OP_CMP);

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign s_a   = (state == SHIFT) ? a_sh[0] : 1'b0;
  assign s_b   = (state == SHIFT) ? b_sh[0] : 1'b0;
  assign s_cin = (state == SHIFT) ? cy_q : 1'b0;
  assign s_m0  = op_q[0];
  assign s_m1  = op_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      op_q   <= '0;
      cnt    <= '0;
      cy_q   <= 1'b0;
      eq_q   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      neg    <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            op_q   <= op;
            cnt    <= '0;
            // SUB is B + ~A + 1: the +1 enters as the initial carry
            cy_q   <= (op == OP_SUB);
            eq_q   <= 1'b1;
            result <= '0;
            carry  <= 1'b0;
            neg    <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (!is_cmp) result <= {s_f, result[WIDTH-1:1]};
          if (arith) cy_q <= s_cout;
          // LSB first, so a later (higher) differing bit overwrites gt/lt
          if (is_cmp) begin
            eq_q <= eq_q & s_f;
            if (!s_f) begin
              gt <= s_cout;
              lt <= s_n;
            end
          end
          if (cnt == LAST) begin
            state <= DONE;
            if (arith) begin
              carry <= s_cout;
              neg   <= s_f;
            end
            if (is_cmp) eq <= eq_q & s_f;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
